// File: rtl/key_event_arb.sv
// Four-key scanner: slow-tick debounce, press/release/long-press detection and a
// round-robin arbiter onto one valid/ready event stream. Define KEY_SYNC_EN to add a
// 2-flop input synchronizer ahead of the scan latch.
module key_event_arb #(
  parameter int SCAN_DIV   = 1000000,
  parameter int LONG_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic [1:0] evt_type,
  output logic [3:0] key_state,
  output logic       overflow
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] TICK_MAX = CW'(SCAN_DIV - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_TICKS - 1);

  logic [3:0]      key_src;
  logic [CW-1:0]   tick_cnt_q;
  logic            tick;
  logic [3:0]      scan_q, prev_q;
  logic [3:0]      press, release_e, long_evt;
  logic [LW-1:0]   long_cnt_q [4];
  logic [3:0][2:0] pend_q, pend_d, set_vec, grant_mask, grant_eff, drop;
  logic            overflow_q;
  logic            evt_valid_q;
  logic [1:0]      evt_key_q, evt_type_q, rr_q;
  logic            load, found;
  logic [1:0]      cand_key, cand_type, idx;

`ifdef KEY_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end
  assign key_src = sync2_q;
`else
  assign key_src = key_in;
`endif

  assign tick = (tick_cnt_q == TICK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_q     <= 4'hF;
      prev_q     <= 4'hF;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
      if (tick) scan_q <= key_src;
      prev_q <= scan_q;
    end
  end

  // Keys are active-low on the pins; key_state and the edges are active-high.
  assign key_state = ~scan_q;
  assign press     = prev_q & ~scan_q;
  assign release_e = ~prev_q & scan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) long_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!key_state[i])
          long_cnt_q[i] <= '0;
        else if (tick && (long_cnt_q[i] != LONG_MAX))
          long_cnt_q[i] <= long_cnt_q[i] + LW'(1);
      end
    end
  end

  always_comb begin
    long_evt = '0;
    set_vec  = '0;
    for (int i = 0; i < 4; i++) begin
      long_evt[i] = tick & key_state[i] & (long_cnt_q[i] == LONG_PRE);
      set_vec[i]  = {release_e[i], long_evt[i], press[i]};
    end
  end

  // Handshake: an event transfers on a clk edge where evt_valid and evt_ready are both
  // high; while evt_valid is high and evt_ready low the payload and pointer hold.
  assign load = ~evt_valid_q | evt_ready;

  // Round-robin search from rr_q; within a key P (bit 0) beats L (bit 1) beats R (bit 2).
  always_comb begin
    found      = 1'b0;
    cand_key   = rr_q;
    cand_type  = 2'b00;
    grant_mask = '0;
    idx        = rr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && (pend_q[idx] != 3'b000)) begin
        found    = 1'b1;
        cand_key = idx;
        if (pend_q[idx][0]) begin
          cand_type = 2'b00;
          grant_mask[idx] = 3'b001;
        end else if (pend_q[idx][1]) begin
          cand_type = 2'b10;
          grant_mask[idx] = 3'b010;
        end else begin
          cand_type = 2'b01;
          grant_mask[idx] = 3'b100;
        end
      end
    end
  end

  assign grant_eff = load ? grant_mask : '0;
  assign pend_d    = (pend_q & ~grant_eff) | set_vec;
  assign drop      = set_vec & pend_q & ~grant_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= 2'b00;
      evt_type_q  <= 2'b00;
      rr_q        <= 2'b00;
    end else begin
      pend_q     <= pend_d;
      overflow_q <= |drop;
      if (load) begin
        evt_valid_q <= found;
        if (found) begin
          evt_key_q  <= cand_key;
          evt_type_q <= cand_type;
          rr_q       <= cand_key + 2'd1;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_arb.sv
// Directed bench for key_event_arb with SCAN_DIV=4, LONG_TICKS=3.
module tb_key_event_arb;
  localparam int SCAN_DIV   = 4;
  localparam int LONG_TICKS = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic       evt_valid, evt_ready;
  logic [1:0] evt_key, evt_type;
  logic [3:0] key_state;
  logic       overflow;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_arb #(.SCAN_DIV(SCAN_DIV), .LONG_TICKS(LONG_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_key(evt_key), .evt_type(evt_type),
    .key_state(key_state), .overflow(overflow)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  got_q[$];
  int unsigned got_cyc[$];
  int          rd_idx = 0;
  int          ovf_cnt = 0;
  int          ks2_cnt = 0;
  int unsigned ks_rise_cyc = 0;
  logic [3:0]  ks_prev = 4'h0;

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      got_q.push_back({evt_key, evt_type});
      got_cyc.push_back(cyc);
    end
    if (overflow) ovf_cnt++;
    if (key_state[2]) ks2_cnt++;
    if (key_state != 4'h0 && ks_prev == 4'h0) ks_rise_cyc = cyc;
    ks_prev = key_state;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_wait(input int n);
    cycles(n * SCAN_DIV);
  endtask

  task automatic expect_evt(input string tag, input logic [1:0] k, input logic [1:0] t,
                            output int unsigned c);
    int budget;
    budget = 200;
    exp_q.push_back({k, t});
    while (got_q.size() <= rd_idx && budget > 0) begin
      cycles(1);
      budget--;
    end
    c = 0;
    if (got_q.size() <= rd_idx) begin
      check_val({tag, " count"}, got_q.size(), rd_idx + 1);
      void'(exp_q.pop_front());
    end else begin
      check_val(tag, got_q[rd_idx], exp_q.pop_front());
      c = got_cyc[rd_idx];
      rd_idx++;
    end
  endtask

  task automatic wait_valid(input string tag);
    int budget;
    budget = 40;
    while (!evt_valid && budget > 0) begin
      cycles(1);
      budget--;
    end
    check_val(tag, evt_valid, 1);
  endtask

  int unsigned c0, c1, c2, c3;
  int base;

  initial begin
    rst_n = 1'b0;
    key_in = 4'hF;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst valid", evt_valid, 0);
    check_val("rst key", evt_key, 0);
    check_val("rst type", evt_type, 0);
    check_val("rst key_state", key_state, 0);
    check_val("rst overflow", overflow, 0);
    rst_n = 1'b1;
    cycles(2);

    // key 2 held two ticks: press then release, no long
    evt_ready = 1'b1;
    base = ks2_cnt;
    key_in = 4'b1011;
    cycles(8);
    key_in = 4'hF;
    tick_wait(3);
    expect_evt("t1 press", 2'd2, 2'b00, c0);
    expect_evt("t1 release", 2'd2, 2'b01, c1);
    check_val("t1 no extra", got_q.size(), rd_idx);
    check_val("t1 key_state cycles", ks2_cnt - base, 2 * SCAN_DIV);

    // key 0 held five ticks: press, one long on third held tick, release
    key_in = 4'b1110;
    cycles(20);
    key_in = 4'hF;
    tick_wait(3);
    expect_evt("t2 press", 2'd0, 2'b00, c0);
    expect_evt("t2 long", 2'd0, 2'b10, c1);
    expect_evt("t2 release", 2'd0, 2'b01, c2);
    check_val("t2 long delay", c1 - c0, 11);
    check_val("t2 no extra", got_q.size(), rd_idx);

    // all four keys on one tick after reset: RR order 0..3, back to back
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    rd_idx = got_q.size();
    key_in = 4'b0000;
    cycles(4);
    key_in = 4'hF;
    tick_wait(3);
    expect_evt("t3 press k0", 2'd0, 2'b00, c0);
    check_val("t3 latency", c0 - ks_rise_cyc, 2);
    expect_evt("t3 press k1", 2'd1, 2'b00, c1);
    check_val("t3 gap01", c1 - c0, 1);
    expect_evt("t3 press k2", 2'd2, 2'b00, c2);
    check_val("t3 gap12", c2 - c1, 1);
    expect_evt("t3 press k3", 2'd3, 2'b00, c3);
    check_val("t3 gap23", c3 - c2, 1);
    expect_evt("t3 rel k0", 2'd0, 2'b01, c0);
    expect_evt("t3 rel k1", 2'd1, 2'b01, c0);
    expect_evt("t3 rel k2", 2'd2, 2'b01, c0);
    expect_evt("t3 rel k3", 2'd3, 2'b01, c0);
    check_val("t3 no extra", got_q.size(), rd_idx);

    // backpressure: payload held for 10 ticks, then queued events stream out
    evt_ready = 1'b0;
    key_in = 4'b1001;
    cycles(4);
    key_in = 4'hF;
    wait_valid("t4 valid rise");
    for (int i = 0; i < 10 * SCAN_DIV; i++) begin
      cycles(1);
      check_val("t4 hold valid", evt_valid, 1);
      check_val("t4 hold key", evt_key, 1);
      check_val("t4 hold type", evt_type, 0);
    end
    evt_ready = 1'b1;
    expect_evt("t4 k1 press", 2'd1, 2'b00, c0);
    expect_evt("t4 k2 press", 2'd2, 2'b00, c1);
    check_val("t4 next clk", c1 - c0, 1);
    expect_evt("t4 k1 rel", 2'd1, 2'b01, c2);
    expect_evt("t4 k2 rel", 2'd2, 2'b01, c3);
    tick_wait(2);
    check_val("t4 no extra", got_q.size(), rd_idx);

    // overflow: output busy with key 3, key 1 pressed, released, pressed again
    evt_ready = 1'b0;
    base = ovf_cnt;
    key_in = 4'b0111;
    cycles(4);
    key_in = 4'b0101;
    cycles(4);
    key_in = 4'b0111;
    cycles(4);
    key_in = 4'b0101;
    cycles(8);
    check_val("t5 overflow pulses", ovf_cnt - base, 1);
    evt_ready = 1'b1;
    expect_evt("t5 k3 press", 2'd3, 2'b00, c0);
    expect_evt("t5 k1 press", 2'd1, 2'b00, c1);
    expect_evt("t5 k3 long", 2'd3, 2'b10, c2);
    expect_evt("t5 k1 rel kept", 2'd1, 2'b01, c3);
    key_in = 4'hF;
    tick_wait(6);
    rd_idx = got_q.size();

    // async reset while an event is held
    evt_ready = 1'b0;
    key_in = 4'b1011;
    wait_valid("t6 valid rise");
    cycles(2);
    check_val("t6 held key", evt_key, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6 async valid", evt_valid, 0);
    check_val("t6 async key", evt_key, 0);
    check_val("t6 async type", evt_type, 0);
    check_val("t6 async key_state", key_state, 0);
    check_val("t6 async overflow", overflow, 0);
    key_in = 4'hF;
    cycles(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    rd_idx = got_q.size();
    tick_wait(5);
    check_val("t6 no stale event", got_q.size(), rd_idx);
    check_val("t6 idle valid", evt_valid, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
